// File: rtl/ntt_stage_sequencer.sv
`default_nettype none
// ntt_stage_sequencer: steps the in-place NTT butterfly datapath through all stages.
// Revision 1.0 - initial release.
module ntt_stage_sequencer #(
  parameter int RING_DEPTH = 8,
  parameter int PIPE_LAT   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  output logic                          busy,
  output logic                          rd_en,
  output logic [RING_DEPTH-2:0]         rd_addr,
  output logic [RING_DEPTH-2:0]         tw_addr,
  output logic                          wr_en,
  output logic [RING_DEPTH-2:0]         wr_addr,
  output logic                          out_valid,
  output logic [$clog2(RING_DEPTH)-1:0] stage,
  output logic                          last_stage,
  output logic                          done
);

  localparam int AW = RING_DEPTH - 1;
  localparam int SW = $clog2(RING_DEPTH);
  localparam int DW = AW + 2;
  localparam logic [AW-1:0] K_LAST     = {AW{1'b1}};
  localparam logic [SW-1:0] STAGE_LAST = SW'(RING_DEPTH - 1);
  localparam logic [3:0]    DRAIN_LAST = 4'(PIPE_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] k, k_nxt;
  logic [SW-1:0] stage_idx, stage_nxt;
  logic [3:0]    drain_cnt, drain_nxt;
  logic [SW-1:0] shamt;
  logic [DW-1:0] dline [PIPE_LAT];
  logic [DW-1:0] tail;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      k         <= '0;
      stage_idx <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      k         <= k_nxt;
      stage_idx <= stage_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    stage_nxt = stage_idx;
    drain_nxt = drain_cnt;
    if (abort) begin
      state_nxt = IDLE;
      k_nxt     = '0;
      stage_nxt = '0;
      drain_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = READ;
            k_nxt     = '0;
            stage_nxt = '0;
          end
        end
        READ: begin
          if (k == K_LAST) begin
            state_nxt = DRAIN;
            k_nxt     = '0;
          end else begin
            k_nxt = k + AW'(1);
          end
        end
        DRAIN: begin
          // Waiting out the pipeline keeps stage s+1 reads behind all stage s writes.
          if (drain_cnt == DRAIN_LAST) begin
            drain_nxt = '0;
            if (stage_idx == STAGE_LAST) begin
              state_nxt = FINISH;
            end else begin
              stage_nxt = stage_idx + SW'(1);
              state_nxt = READ;
            end
          end else begin
            drain_nxt = drain_cnt + 4'd1;
          end
        end
        FINISH: begin
          state_nxt = IDLE;
          stage_nxt = '0;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy       = (state == READ) || (state == DRAIN);
  assign rd_en      = (state == READ);
  assign rd_addr    = k;
  assign shamt      = STAGE_LAST - stage_idx;
  assign tw_addr    = (k >> shamt) << shamt;
  assign stage      = stage_idx;
  assign last_stage = busy && (stage_idx == STAGE_LAST);
  assign done       = (state == FINISH);

  // Read-side tags delayed to line up with the PE result; abort drops anything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PIPE_LAT; i++) dline[i] <= '0;
    end else if (abort) begin
      for (int i = 0; i < PIPE_LAT; i++) dline[i] <= '0;
    end else begin
      dline[0] <= {rd_en, k, last_stage};
      for (int i = 1; i < PIPE_LAT; i++) dline[i] <= dline[i-1];
    end
  end

  assign tail      = dline[PIPE_LAT-1];
  assign wr_en     = tail[DW-1] & ~tail[0];
  assign out_valid = tail[DW-1] & tail[0];
  assign wr_addr   = tail[AW:1];

endmodule
`default_nettype wire

// File: tb/tb_ntt_stage_sequencer.sv
`default_nettype none
// tb_ntt_stage_sequencer: randomized and directed checks against a timing-formula model.
module tb_ntt_stage_sequencer;

  localparam int RD  = 4;
  localparam int PL  = 2;
  localparam int H   = 8;
  localparam int P   = H + PL;
  localparam int TOT = RD * P;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic       busy, rd_en, wr_en, out_valid, last_stage, done;
  logic [2:0] rd_addr, tw_addr, wr_addr;
  logic [1:0] stage;

  ntt_stage_sequencer #(.RING_DEPTH(RD), .PIPE_LAT(PL)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr), .tw_addr(tw_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .out_valid(out_valid),
    .stage(stage), .last_stage(last_stage), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: cycles elapsed since an accepted start; everything follows from that count.
  int   running = 0;
  int   r = 0;
  logic cur_s, cur_a;
  logic e_busy, e_rd, e_wr, e_ov, e_last, e_done;
  logic [2:0] e_rd_addr, e_tw, e_wr_addr;
  logic [1:0] e_stage;

  task automatic model_eval();
    int s, j, w, sw, jw, sh;
    {e_busy, e_rd, e_wr, e_ov, e_last, e_done} = '0;
    e_rd_addr = '0; e_tw = '0; e_wr_addr = '0; e_stage = '0;
    if (running != 0) begin
      if (r <= TOT) begin
        e_busy  = 1'b1;
        s       = (r - 1) / P;
        j       = (r - 1) % P;
        e_stage = 2'(s);
        e_last  = (s == RD - 1);
        if (j < H) begin
          e_rd      = 1'b1;
          e_rd_addr = 3'(j);
          sh        = RD - 1 - s;
          e_tw      = 3'((j >> sh) << sh);
        end
      end else begin
        e_done = 1'b1;
      end
      w = r - PL;
      if (w >= 1 && w <= TOT) begin
        sw = (w - 1) / P;
        jw = (w - 1) % P;
        if (jw < H) begin
          if (sw == RD - 1) e_ov = 1'b1;
          else              e_wr = 1'b1;
          e_wr_addr = 3'(jw);
        end
      end
    end
  endtask

  task automatic model_advance(input logic sv, input logic av);
    if (av) running = 0;
    else if (running != 0) begin
      if (r == TOT + 1) running = 0;
      else r = r + 1;
    end else if (sv) begin
      running = 1;
      r = 1;
    end
  endtask

  task automatic drive(input logic sv, input logic av);
    start = sv; abort = av; cur_s = sv; cur_a = av;
    @(negedge clk);
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance(cur_s, cur_a);
    #1;
  endtask

  function automatic logic [16:0] obs_word();
    return {busy, rd_en, wr_en, out_valid, last_stage, done,
            e_rd ? {rd_addr, tw_addr} : 6'd0,
            (e_wr | e_ov) ? wr_addr : 3'd0,
            e_busy ? stage : 2'd0};
  endfunction

  function automatic logic [16:0] exp_word();
    return {e_busy, e_rd, e_wr, e_ov, e_last, e_done,
            e_rd_addr, e_tw, e_wr_addr, e_stage};
  endfunction

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; abort = 1'b0; cur_s = 1'b0; cur_a = 1'b0;
    #2;
    checks++;
    if ({busy, rd_en, wr_en, out_valid, last_stage, done, rd_addr, tw_addr, wr_addr, stage} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0",
               {busy, rd_en, wr_en, out_valid, last_stage, done, rd_addr, tw_addr, wr_addr, stage});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0);
      checks++;
      if (obs_word() !== exp_word()) begin
        errors++; $display("FAIL reset_idle c=%0d: got %h want %h", c, obs_word(), exp_word());
      end
      tick();
    end
  endtask

  task automatic test_basic_run();
    for (int c = 0; c <= 44; c++) begin
      drive(c == 0, 1'b0);
      checks++;
      if (obs_word() !== exp_word()) begin
        errors++; $display("FAIL basic_model c=%0d: got %h want %h", c, obs_word(), exp_word());
      end
      checks++;
      if (done !== (c == 41) || busy !== (c >= 1 && c <= 40)) begin
        errors++; $display("FAIL basic_done_busy c=%0d: got done=%b busy=%b", c, done, busy);
      end
      if (c >= 1 && c <= 8) begin
        checks++;
        if (rd_en !== 1'b1 || rd_addr !== 3'(c - 1)) begin
          errors++; $display("FAIL basic_read c=%0d: got en=%b addr=%0d want 1/%0d", c, rd_en, rd_addr, c - 1);
        end
      end
      if (c >= 3 && c <= 10) begin
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 3'(c - 3)) begin
          errors++; $display("FAIL basic_write c=%0d: got en=%b addr=%0d want 1/%0d", c, wr_en, wr_addr, c - 3);
        end
      end
      if (c == 11) begin
        checks++;
        if (rd_en !== 1'b1 || rd_addr !== 3'd0 || stage !== 2'd1) begin
          errors++; $display("FAIL stage1_start: got en=%b addr=%0d stage=%0d want 1/0/1", rd_en, rd_addr, stage);
        end
      end
      if (c >= 31 && c <= 41) begin
        checks++;
        if (wr_en !== 1'b0 || out_valid !== (c >= 33 && c <= 40) ||
            (c <= 40 && last_stage !== 1'b1)) begin
          errors++; $display("FAIL last_stage c=%0d: got wr=%b ov=%b last=%b", c, wr_en, out_valid, last_stage);
        end
        if (c >= 33 && c <= 40) begin
          checks++;
          if (wr_addr !== 3'(c - 33)) begin
            errors++; $display("FAIL out_addr c=%0d: got %0d want %0d", c, wr_addr, c - 33);
          end
        end
      end
      tick();
    end
  endtask

  task automatic test_twiddle();
    logic [2:0] tw1 [8];
    tw1 = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd4, 3'd4, 3'd4};
    for (int c = 0; c <= 44; c++) begin
      drive(c == 0, 1'b0);
      if ((c >= 1 && c <= 8) || (c >= 11 && c <= 18) || (c >= 31 && c <= 38)) begin
        logic [2:0] want;
        if (c <= 8)       want = 3'd0;
        else if (c <= 18) want = tw1[c - 11];
        else              want = 3'(c - 31);
        checks++;
        if (tw_addr !== want) begin
          errors++; $display("FAIL twiddle c=%0d: got %0d want %0d", c, tw_addr, want);
        end
      end
      tick();
    end
  endtask

  task automatic test_spurious_start();
    for (int c = 0; c <= 86; c++) begin
      drive(c == 0 || c == 5 || c == 41 || c == 42, 1'b0);
      checks++;
      if (obs_word() !== exp_word()) begin
        errors++; $display("FAIL spurious_model c=%0d: got %h want %h", c, obs_word(), exp_word());
      end
      if (c <= 43) begin
        checks++;
        if (done !== (c == 41)) begin
          errors++; $display("FAIL spurious_done c=%0d: got %b", c, done);
        end
      end
      if (c == 42 || c == 43) begin
        checks++;
        if (rd_en !== (c == 43) || (c == 43 && (rd_addr !== 3'd0 || stage !== 2'd0))) begin
          errors++; $display("FAIL restart c=%0d: got en=%b addr=%0d stage=%0d", c, rd_en, rd_addr, stage);
        end
      end
      tick();
    end
  endtask

  task automatic test_abort();
    for (int c = 0; c <= 32; c++) begin
      drive(c == 0 || c == 20, c == 15 || c == 31);
      checks++;
      if (obs_word() !== exp_word()) begin
        errors++; $display("FAIL abort_model c=%0d: got %h want %h", c, obs_word(), exp_word());
      end
      if (c >= 16 && c <= 20) begin
        checks++;
        if (busy !== 1'b0 || wr_en !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
          errors++; $display("FAIL abort_quiet c=%0d: got busy=%b wr=%b ov=%b done=%b", c, busy, wr_en, out_valid, done);
        end
      end
      if (c == 21) begin
        checks++;
        if (rd_en !== 1'b1 || rd_addr !== 3'd0 || stage !== 2'd0) begin
          errors++; $display("FAIL abort_restart: got en=%b addr=%0d stage=%0d", rd_en, rd_addr, stage);
        end
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c <= 5; c++) begin
      drive(c == 0, 1'b0);
      tick();
    end
    #2 reset = 1'b0;
    running = 0;
    #1;
    checks++;
    if ({busy, rd_en, wr_en, out_valid, last_stage, done, rd_addr, tw_addr, wr_addr, stage} !== 17'd0) begin
      errors++;
      $display("FAIL async_reset: got %h want 0",
               {busy, rd_en, wr_en, out_valid, last_stage, done, rd_addr, tw_addr, wr_addr, stage});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      drive(c == 6, c == 11);
      checks++;
      if (obs_word() !== exp_word()) begin
        errors++; $display("FAIL post_reset c=%0d: got %h want %h", c, obs_word(), exp_word());
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
      checks++;
      if (obs_word() !== exp_word()) begin
        errors++; $display("FAIL random c=%0d: got %h want %h", c, obs_word(), exp_word());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_twiddle();
    test_spurious_start();
    test_abort();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
